// File: rtl/mult_pkg.sv
// Shared constants for the sequential radix-2 Booth multiplier.
// Optional build macro used by this block: MULT_ZERO_BYPASS_EN.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int unsigned MULT_STEPS = 32;

  // Booth recoding of the {q0, q-1} pair
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into the
// upper half of the accumulator, then arithmetic shift right by one.
module booth_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0] upper_ext;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    // One guard bit keeps the true sign when M is the most negative value
    upper_ext = {acc_i[2*WIDTH], acc_i[2*WIDTH:WIDTH+1]};
    m_ext     = {m_i[WIDTH-1], m_i};
    case (acc_i[1:0])
      BOOTH_ADD: sum = upper_ext + m_ext;
      BOOTH_SUB: sum = upper_ext - m_ext;
      default:   sum = upper_ext;
    endcase
    acc_o = {sum, acc_i[WIDTH:1]};
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed Booth multiplier: FSM, step counter and registers.
// Define MULT_ZERO_BYPASS_EN to finish immediately when an operand is zero.
module booth_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             mult_control,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_end,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [2*WIDTH:0] acc_step;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             end_q, end_d;
  logic             zero_op;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (a_in == '0) || (b_in == '0);
`else
  assign zero_op = 1'b0;
`endif

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (acc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    end_d   = end_q;
    case (state_q)
      ST_IDLE: begin
        if (mult_control) begin
          if (zero_op) begin
            hi_d    = '0;
            lo_d    = '0;
            end_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            m_d     = a_in;
            acc_d   = {{WIDTH{1'b0}}, b_in, 1'b0};
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MULT_STEPS - 1)) begin
          hi_d    = acc_step[2*WIDTH:WIDTH+1];
          lo_d    = acc_step[WIDTH:1];
          end_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        end_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        end_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      end_q   <= end_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign mult_end = end_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: cycle-level behavioural model plus
// directed literal cases and randomized traffic.
module tb_booth_mult;

`ifdef MULT_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int ZLAT = BYPASS ? 1 : 32;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        mult_control = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] hi_out, lo_out;
  logic        mult_end, busy;

  int n_checks = 0;
  int n_fail = 0;

  booth_mult #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .mult_control (mult_control),
    .a_in         (a_in),
    .b_in         (b_in),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .mult_end     (mult_end),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  // Model: remaining steps, done flag, and the last completed product
  int          m_rem = 0;
  logic        m_end = 1'b0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      m_rem  <= 0;
      m_end  <= 1'b0;
      m_prod <= '0;
    end else if (m_end) begin
      m_end <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_end  <= 1'b1;
        m_prod <= m_pend;
      end
    end else if (mult_control) begin
      m_pend <= prod(a_in, b_in);
      if (BYPASS && (a_in == 0 || b_in == 0)) begin
        m_end  <= 1'b1;
        m_prod <= '0;
      end else begin
        m_rem <= 32;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc mult_end", 64'(mult_end), 64'(m_end));
    chk("cyc busy", 64'(busy), 64'((m_rem > 0) || m_end));
    chk("cyc hi", 64'(hi_out), 64'(m_prod[63:32]));
    chk("cyc lo", 64'(lo_out), 64'(m_prod[31:0]));
  end

  // Starts from idle just after a rising edge; returns idle just after an edge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc, input string tag);
    int cyc;
    a_in = a;
    b_in = b;
    mult_control = 1'b1;
    @(posedge clk);
    #1;
    mult_control = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!mult_end && cyc < 100);
    chk({tag, " latency"}, 64'(cyc), 64'(ecyc));
    chk({tag, " hi"}, 64'(hi_out), 64'(eh));
    chk({tag, " lo"}, 64'(lo_out), 64'(el));
    chk({tag, " model"}, m_prod, {eh, el});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ends;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi_out), 64'h0);
    chk("reset lo", 64'(lo_out), 64'h0);
    chk("reset end", 64'(mult_end), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    reset_in = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'd3, 32'd5, 32'h0, 32'h0000_000F, 32, "3x5");
    run_op(32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32, "-7x3");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32, "-1x-1");
    run_op(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 32, "min x min");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 32, "max x min");
    run_op(32'd0, 32'd12345, 32'h0, 32'h0, ZLAT, "0x12345");
    run_op(32'd5, 32'd0, 32'h0, 32'h0, ZLAT, "5x0");

    // Extra start pulses during RUN and at completion are ignored
    a_in = 32'd2;
    b_in = 32'd2;
    mult_control = 1'b1;
    @(posedge clk);
    #1;
    ends = 0;
    for (int i = 1; i <= 33; i++) begin
      mult_control = (i == 10 || i == 32);
      @(posedge clk);
      #1;
      if (mult_end) ends++;
    end
    mult_control = 1'b0;
    chk("2x2 end count", 64'(ends), 64'd1);
    chk("2x2 lo", 64'(lo_out), 64'd4);
    run_op(32'd11, 32'd13, 32'h0, 32'd143, 32, "restart");

    // Abort with reset mid-operation
    a_in = 32'd9;
    b_in = 32'd9;
    mult_control = 1'b1;
    @(posedge clk);
    #1;
    mult_control = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset_in = 1'b0;
    #1;
    chk("abort hi", 64'(hi_out), 64'h0);
    chk("abort lo", 64'(lo_out), 64'h0);
    chk("abort busy", 64'(busy), 64'h0);
    ends = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mult_end) ends++;
    end
    chk("abort no end", 64'(ends), 64'd0);
    reset_in = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd6, 32'd7, 32'h0, 32'd42, 32, "6x7");

    // Random traffic with noisy start requests and one reset
    for (int i = 0; i < 3000; i++) begin
      mult_control = ($urandom % 5 == 0);
      a_in = pick();
      b_in = pick();
      reset_in = !(i == 1500 || i == 1501);
      @(posedge clk);
      #1;
    end
    mult_control = 1'b0;
    reset_in = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
